// File: rtl/sq_g_motion_ctrl.sv
// Green-square motion controller for the task-D OLED screen: debounced buttons
// latch a direction, and the square steps one pixel at a fixed rate inside the big square.
module sq_g_motion_ctrl #(
  parameter int SQ_SIZE         = 5,
  parameter int BIG_SIZE        = 25,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int STEP_DIV        = 2_222_222
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       password_D,
  input  logic [6:0] sq_big_left,
  input  logic [5:0] sq_big_top,
  output logic [6:0] sq_g_left,
  output logic [5:0] sq_g_top,
  output logic [6:0] sq_g_right,
  output logic [5:0] sq_g_bot,
  output logic       sq_g_moving
);

  localparam int MAX_OFF  = BIG_SIZE - SQ_SIZE;
  localparam int HOME_OFF = MAX_OFF / 2;
  localparam int DB_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int ST_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [6:0]      X_MAX     = 7'(MAX_OFF);
  localparam logic [5:0]      Y_MAX     = 6'(MAX_OFF);
  localparam logic [6:0]      X_HOME    = 7'(HOME_OFF);
  localparam logic [5:0]      Y_HOME    = 6'(HOME_OFF);
  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [ST_W-1:0] STEP_LAST = ST_W'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_LEFT,
    S_RIGHT
  } state_t;

  // Button vector order, highest priority first: C, U, D, L, R
  logic [4:0]      w_btnRaw;
  logic [4:0]      r_sync1;
  logic [4:0]      r_sync2;
  logic [4:0]      r_deb;
  logic [4:0]      r_debPrev;
  logic [DB_W-1:0] r_dbCnt [5];
  logic [4:0]      w_press;

  state_t          r_state;
  state_t          w_stateNext;
  logic [6:0]      r_offX;
  logic [6:0]      w_offXNext;
  logic [5:0]      r_offY;
  logic [5:0]      w_offYNext;
  logic [ST_W-1:0] r_stepCnt;
  logic [ST_W-1:0] w_stepCntNext;
  logic            w_step;

  assign w_btnRaw = {btnC, btnU, btnD, btnL, btnR};
  assign w_press  = r_deb & ~r_debPrev;

  // The debounced level flips on the (DEBOUNCE_CYCLES+1)th differing sample,
  // which lands the flip 2+DEBOUNCE_CYCLES edges after the raw level is first seen.
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_debPrev <= '0;
      for (int i = 0; i < 5; i++) r_dbCnt[i] <= '0;
    end else begin
      r_sync1   <= w_btnRaw;
      r_sync2   <= r_sync1;
      r_debPrev <= r_deb;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dbCnt[i] == DB_MAX) begin
            r_deb[i]   <= r_sync2[i];
            r_dbCnt[i] <= '0;
          end else begin
            r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
          end
        end else begin
          r_dbCnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_offX    <= X_HOME;
      r_offY    <= Y_HOME;
      r_stepCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_offX    <= w_offXNext;
      r_offY    <= w_offYNext;
      r_stepCnt <= w_stepCntNext;
    end
  end

  assign w_step = (r_state != S_IDLE) && (r_stepCnt == STEP_LAST);

  // Step first, then presses: a press toward an edge the step just reached is blocked.
  always_comb begin
    w_stateNext   = r_state;
    w_offXNext    = r_offX;
    w_offYNext    = r_offY;
    w_stepCntNext = r_stepCnt;

    if (w_step) begin
      case (r_state)
        S_UP: begin
          if (r_offY != '0) w_offYNext = r_offY - 1'b1;
          if (w_offYNext == '0) w_stateNext = S_IDLE;
        end
        S_DOWN: begin
          if (r_offY != Y_MAX) w_offYNext = r_offY + 1'b1;
          if (w_offYNext == Y_MAX) w_stateNext = S_IDLE;
        end
        S_LEFT: begin
          if (r_offX != '0) w_offXNext = r_offX - 1'b1;
          if (w_offXNext == '0) w_stateNext = S_IDLE;
        end
        S_RIGHT: begin
          if (r_offX != X_MAX) w_offXNext = r_offX + 1'b1;
          if (w_offXNext == X_MAX) w_stateNext = S_IDLE;
        end
        default: ;
      endcase
    end

    if (w_press[4]) begin
      w_stateNext = S_IDLE;
    end else if (w_press[3]) begin
      if (w_offYNext != '0) w_stateNext = S_UP;
    end else if (w_press[2]) begin
      if (w_offYNext != Y_MAX) w_stateNext = S_DOWN;
    end else if (w_press[1]) begin
      if (w_offXNext != '0) w_stateNext = S_LEFT;
    end else if (w_press[0]) begin
      if (w_offXNext != X_MAX) w_stateNext = S_RIGHT;
    end

    if (!password_D) begin
      w_stateNext = S_IDLE;
      w_offXNext  = X_HOME;
      w_offYNext  = Y_HOME;
    end

    if ((w_stateNext != r_state) || (w_stateNext == S_IDLE) || w_step) begin
      w_stepCntNext = '0;
    end else begin
      w_stepCntNext = r_stepCnt + 1'b1;
    end
  end

  assign sq_g_left   = sq_big_left + r_offX;
  assign sq_g_right  = sq_g_left + 7'(SQ_SIZE - 1);
  assign sq_g_top    = sq_big_top + r_offY;
  assign sq_g_bot    = sq_g_top + 6'(SQ_SIZE - 1);
  assign sq_g_moving = (r_state != S_IDLE);

endmodule

// File: tb/tb_sq_g_motion_ctrl.sv
// Scoreboard bench for sq_g_motion_ctrl: stimulus queues cycle-tagged expected
// outputs, and a negedge monitor pops and compares them when their cycle arrives.
module tb_sq_g_motion_ctrl;

  logic       clock;
  logic       reset_n;
  logic [4:0] btns;
  logic       password_D;
  logic [6:0] bigLeft;
  logic [5:0] bigTop;
  logic [6:0] gLeft;
  logic [5:0] gTop;
  logic [6:0] gRight;
  logic [5:0] gBot;
  logic       gMoving;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [6:0] left;
    logic [5:0] top;
    logic [6:0] right;
    logic [5:0] bot;
    logic       moving;
    string      name;
  } exp_t;

  exp_t sb[$];

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  sq_g_motion_ctrl #(
    .SQ_SIZE(5),
    .BIG_SIZE(25),
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV(8)
  ) dut (
    .clock_100mhz(clock),
    .reset_n(reset_n),
    .btnC(btns[4]),
    .btnU(btns[3]),
    .btnD(btns[2]),
    .btnL(btns[1]),
    .btnR(btns[0]),
    .password_D(password_D),
    .sq_big_left(bigLeft),
    .sq_big_top(bigTop),
    .sq_g_left(gLeft),
    .sq_g_top(gTop),
    .sq_g_right(gRight),
    .sq_g_bot(gBot),
    .sq_g_moving(gMoving)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cyc counts rising edges; it is stable whenever read at a falling edge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic expectAt(input int c, input int l, input int t, input logic m, input string name);
    exp_t e;
    e.cyc    = c;
    e.left   = 7'(l);
    e.top    = 6'(t);
    e.right  = 7'(l + 4);
    e.bot    = 6'(t + 4);
    e.moving = m;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (gLeft !== e.left || gTop !== e.top || gRight !== e.right ||
        gBot !== e.bot || gMoving !== e.moving) begin
      errors++;
      $display("[TB] FAIL %s @cyc %0d: got L/T/R/B/mv=%0d/%0d/%0d/%0d/%0b expected %0d/%0d/%0d/%0d/%0b",
               e.name, cyc, gLeft, gTop, gRight, gBot, gMoving,
               e.left, e.top, e.right, e.bot, e.moving);
    end
  endtask

  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Called at a falling edge; holds the buttons for 'hold' cycles, then releases.
  task automatic applyStimulus(input logic [4:0] b, input int hold);
    btns = b;
    repeat (hold) @(negedge clock);
    btns = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got cyc=%0d expected end before timeout", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    reset_n    = 1'b0;
    password_D = 1'b1;
    btns       = '0;
    bigLeft    = 7'd35;
    bigTop     = 6'd19;
    @(negedge clock);

    expectAt(2, 45, 29, 1'b0, "inReset");
    expectAt(5, 45, 29, 1'b0, "afterReset");
    waitUntil(3);
    reset_n = 1'b1;
    waitUntil(8);

    // Right to edge: offset 10 -> 20 in ten steps
    t = cyc;
    expectAt(t + 7,  45, 29, 1'b0, "rightNotYet");
    expectAt(t + 8,  45, 29, 1'b1, "rightEntered");
    expectAt(t + 15, 45, 29, 1'b1, "rightBeforeStep");
    expectAt(t + 16, 46, 29, 1'b1, "rightStep1");
    expectAt(t + 24, 47, 29, 1'b1, "rightStep2");
    expectAt(t + 87, 54, 29, 1'b1, "rightStep9");
    expectAt(t + 88, 55, 29, 1'b0, "rightEdgeStop");
    expectAt(t + 100, 55, 29, 1'b0, "rightHeld");
    applyStimulus(B_R, 10);
    waitUntil(t + 100);

    t = cyc;
    expectAt(t + 20, 55, 29, 1'b0, "glitchShort");
    applyStimulus(B_U, 3);
    waitUntil(t + 20);

    // Long UP press, then reverse to LEFT, then stop with C
    t = cyc;
    expectAt(t + 7,   55, 29, 1'b0, "upNotYet");
    expectAt(t + 8,   55, 29, 1'b1, "upEntered");
    expectAt(t + 16,  55, 28, 1'b1, "upStep1");
    expectAt(t + 24,  55, 27, 1'b1, "upStep2");
    expectAt(t + 32,  55, 27, 1'b1, "reverseRestart");
    expectAt(t + 34,  54, 27, 1'b1, "leftStep1");
    expectAt(t + 43,  53, 27, 1'b1, "leftStep2");
    expectAt(t + 44,  53, 27, 1'b0, "stopC");
    expectAt(t + 60,  53, 27, 1'b0, "frozenA");
    expectAt(t + 144, 53, 27, 1'b0, "frozenB");
    applyStimulus(B_U, 6);
    waitUntil(t + 18);
    applyStimulus(B_L, 6);
    waitUntil(t + 36);
    applyStimulus(B_C, 6);
    waitUntil(t + 150);

    t = cyc;
    expectAt(t + 8,  53, 27, 1'b1, "prioMoving");
    expectAt(t + 16, 53, 26, 1'b1, "prioUpWins");
    applyStimulus(B_U | B_L, 6);
    waitUntil(t + 20);

    t = cyc;
    expectAt(t + 8,   53, 25, 1'b1, "leftToEdge");
    expectAt(t + 151, 36, 25, 1'b1, "leftBeforeEdge");
    expectAt(t + 152, 35, 25, 1'b0, "leftEdgeStop");
    applyStimulus(B_L, 6);
    waitUntil(t + 160);

    t = cyc;
    expectAt(t + 8,  35, 25, 1'b0, "blockedLeftA");
    expectAt(t + 30, 35, 25, 1'b0, "blockedLeftB");
    applyStimulus(B_L, 6);
    waitUntil(t + 40);

    // Task disable mid-motion, presses ignored while disabled
    t = cyc;
    expectAt(t + 8,  35, 25, 1'b1, "rightAgain");
    expectAt(t + 20, 36, 25, 1'b1, "preDisable");
    expectAt(t + 21, 45, 29, 1'b0, "disableHome");
    expectAt(t + 50, 45, 29, 1'b0, "disabledPress");
    expectAt(t + 70, 45, 29, 1'b0, "reEnabled");
    applyStimulus(B_R, 6);
    waitUntil(t + 20);
    password_D = 1'b0;
    waitUntil(t + 30);
    applyStimulus(B_D, 6);
    waitUntil(t + 60);
    password_D = 1'b1;
    waitUntil(t + 80);

    // Asynchronous reset mid-motion
    t = cyc;
    expectAt(t + 20, 45, 30, 1'b1, "preReset");
    expectAt(t + 21, 45, 29, 1'b0, "asyncReset");
    expectAt(t + 30, 45, 29, 1'b0, "postReset");
    applyStimulus(B_D, 6);
    waitUntil(t + 20);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    waitUntil(t + 25);
    reset_n = 1'b1;
    waitUntil(t + 35);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no check at cyc %0d, expected it to be checked", e.name, e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
